// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder slice.
//   WORD_W       : data word width in bits
//   mem_size_t   : access size encoding carried on req_size
//   dmem_state_t : responder FSM states
package mem_if_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering between the core and a 32-bit RAM word.
// Ports:
//   size       in  2   access size (byte/half/word; 3 yields no enables)
//   lane       in  2   byte address within the word (addr[1:0])
//   uns_flag   in  1   1 = zero-extend loads, 0 = sign-extend
//   ram_word   in  32  word read from RAM
//   store_data in  32  right-justified store data
//   byte_en    out 4   write enables, one per byte lane
//   write_word out 32  store data replicated onto every lane
//   load_data  out 32  selected lane(s) shifted to bit 0 and extended
module dmem_lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              uns_flag,
  input  logic [WORD_W-1:0] ram_word,
  input  logic [WORD_W-1:0] store_data,
  output logic [3:0]        byte_en,
  output logic [WORD_W-1:0] write_word,
  output logic [WORD_W-1:0] load_data
);

  logic [WORD_W-1:0] shifted_s;

  // Lane enables, write replication and load extension per access size
  always_comb begin
    shifted_s  = ram_word >> {lane, 3'b000};
    byte_en    = 4'b0000;
    write_word = store_data;
    load_data  = {WORD_W{1'b0}};
    case (size)
      MEM_BYTE: begin
        byte_en    = 4'b0001 << lane;
        write_word = {4{store_data[7:0]}};
        if (uns_flag) begin
          load_data = {24'd0, shifted_s[7:0]};
        end else begin
          load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      MEM_HALF: begin
        // Half-word lanes are picked by addr[1]; addr[0] is an alignment error upstream
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        write_word = {2{store_data[15:0]}};
        if (uns_flag) begin
          load_data = {16'd0, shifted_s[15:0]};
        end else begin
          load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      MEM_WORD: begin
        byte_en    = 4'b1111;
        write_word = store_data;
        load_data  = ram_word;
      end
      default: begin
        byte_en    = 4'b0000;
        write_word = store_data;
        load_data  = {WORD_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: accepts one load/store at a time on a valid/ready
// request channel, accesses a word-organised synchronous RAM, and returns the
// result READ_LATENCY cycles later on a valid/ready response channel.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_addr, req_we        byte address, 1 = store
//   req_size, req_unsigned  access size, zero-extend loads
//   req_wdata               right-justified store data
//   resp_valid/resp_ready   response handshake
//   resp_rdata, resp_err    extended load data (0 for stores/errors), error flag
module dmem_responder
  import mem_if_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 33-bit bounds so a region ending at the top of the address space cannot wrap
  localparam logic [32:0] BASE_33  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_33 = BASE_33 + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(READ_LATENCY - 1);

  logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

  dmem_state_t       state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              req_ready_r, resp_valid_r;
  logic              we_r, err_r, uns_r;
  logic [1:0]        size_r, lane_r;
  logic [WORD_W-1:0] rword_r;

  logic              accept_s, range_err_s, align_err_s, err_s;
  logic [31:0]       offset_s;
  logic [IDX_W-1:0]  idx_s;
  logic [1:0]        al_size_s, al_lane_s;
  logic              al_uns_s;
  logic [3:0]        byte_en_s;
  logic [WORD_W-1:0] write_word_s, load_data_s;

  assign accept_s = req_valid && req_ready_r && !reset;
  assign offset_s = req_addr - BASE_ADDR;
  assign idx_s    = IDX_W'(offset_s >> 2);

  // Request error decode: out-of-range, misaligned, or illegal size
  always_comb begin
    range_err_s = ({1'b0, req_addr} < BASE_33) || ({1'b0, req_addr} >= LIMIT_33);
    case (req_size)
      MEM_BYTE: align_err_s = 1'b0;
      MEM_HALF: align_err_s = req_addr[0];
      MEM_WORD: align_err_s = |req_addr[1:0];
      default:  align_err_s = 1'b1;
    endcase
    err_s = range_err_s || align_err_s;
  end

  // Aligner sees the live request in IDLE (store path) and the latched one afterwards (load path)
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_size_s = req_size;
      al_lane_s = req_addr[1:0];
      al_uns_s  = req_unsigned;
    end else begin
      al_size_s = size_r;
      al_lane_s = lane_r;
      al_uns_s  = uns_r;
    end
  end

  dmem_lane_align u_align (
    .size       (al_size_s),
    .lane       (al_lane_s),
    .uns_flag   (al_uns_s),
    .ram_word   (rword_r),
    .store_data (req_wdata),
    .byte_en    (byte_en_s),
    .write_word (write_word_s),
    .load_data  (load_data_s)
  );

  // Next-state and latency counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_s = CNT_INIT;
          if (READ_LATENCY == 1) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Counter hits zero on the same edge that enters RESP
        if (cnt_r <= 4'd1) begin
          cnt_s   = 4'd0;
          state_s = ST_RESP;
        end else begin
          cnt_s   = cnt_r - 4'd1;
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // FSM state, counter and handshake output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      req_ready_r  <= (state_s == ST_IDLE);
      resp_valid_r <= (state_s == ST_RESP);
    end
  end

  // Decoded request held for the response
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r   <= 1'b0;
      err_r  <= 1'b0;
      uns_r  <= 1'b0;
      size_r <= 2'd0;
      lane_r <= 2'd0;
    end else if (accept_s) begin
      we_r   <= req_we;
      err_r  <= err_s;
      uns_r  <= req_unsigned;
      size_r <= req_size;
      lane_r <= req_addr[1:0];
    end
  end

  // RAM: read into the holding register and byte-enabled write, both at the accept edge
  always_ff @(posedge clk) begin
    if (accept_s) begin
      rword_r <= mem_r[idx_s];
      if (req_we && !err_s) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en_s[i]) begin
            mem_r[idx_s][8*i +: 8] <= write_word_s[8*i +: 8];
          end
        end
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_valid_r && err_r;
  assign resp_rdata = (resp_valid_r && !we_r && !err_r) ? load_data_s : {WORD_W{1'b0}};

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target that answers the core's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Owns a word-organised synchronous RAM. Supports byte, half and word accesses with sign or zero extension on loads.
- Returns an error response for misaligned or out-of-range addresses.
- Sits between the core's memory stage and the data RAM, and replaces the core's single-cycle memory model.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; the addressable range is BASE_ADDR to BASE_ADDR+4*DEPTH_WORDS-1.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- READ_LATENCY, 2: cycles from request acceptance to resp_valid; legal values are 1 to 15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range, or size==3.

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. RAM contents are not cleared.
- States:
  - IDLE: req_ready=1.
  - WAIT: counting latency.
  - RESP: resp_valid=1, holding the response.
- IDLE -> WAIT on req_valid&&req_ready, which is the accept edge. At that edge:
  - Latch the decoded request.
  - Load the counter with READ_LATENCY-1.
  - If READ_LATENCY==1, go directly to RESP.
- WAIT: counter decrements each cycle; moves to RESP when the counter reaches 0.
- Cycle timing: if the accept edge is at cycle N, resp_valid is first high in cycle N+READ_LATENCY.
- RESP -> IDLE on resp_ready. resp_valid, resp_rdata and resp_err hold stable while resp_ready=0.
- req_ready is 1 only in IDLE, so at most one request is in flight. Minimum spacing between accepted requests is READ_LATENCY+1 cycles.
- Error check, evaluated at acceptance:
  - err if size==1 && addr[0]!=0.
  - err if size==2 && addr[1:0]!=0.
  - err if size==3.
  - err if addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS.
  - The range compare is 33-bit to avoid wrap at the top of the address space.
- Word index = (addr-BASE_ADDR)>>2. Byte lane = addr[1:0].
- Store with no error: RAM is written at the accept edge using byte enables.
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - Word: all four lanes get wdata.
  - Unenabled lanes keep their old contents.
- Error store: RAM is untouched.
- Load: the RAM word is read at the accept edge into a holding register. The selected lane(s) are shifted to bit 0 and extended per req_unsigned, which is ignored for word loads.
- Store or error response: resp_rdata=0. resp_err applies in both cases.
- Error responses use the same latency as normal responses.
- Reset asserted in any state: next state is IDLE and any pending response is discarded. A store accepted before reset stays committed.

Decomposition:
- Shared package mem_if_pkg holds:
  - enum mem_size_t (MEM_BYTE=2'd0, MEM_HALF=2'd1, MEM_WORD=2'd2).
  - enum for the FSM states.
  - constant for the word width (32).
- Sub-module dmem_lane_align is purely combinational:
  - Input side: size, lane, unsigned flag, RAM word, store data.
  - Output side: 4-bit byte enable, lane-replicated write word, extended load data.
- The FSM, counter and RAM array stay in dmem_responder.

Test Plan:
- Word store then load, BASE_ADDR=0, READ_LATENCY=2:
  - Store 0xDEADBEEF to 0x10; resp_valid arrives 2 cycles after accept with err=0, rdata=0.
  - Load word from 0x10 -> rdata=0xDEADBEEF.
- Sub-word extension, after the word store above:
  - lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE.
  - lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
- Byte-enable merge: sb 0x55 to 0x11, then lw 0x10 -> 0xDEAD55EF.
- Errors:
  - lw 0x12 -> err=1, rdata=0.
  - sh 0x11 -> err=1; a later lw 0x10 shows the word unchanged.
  - Access at 4*DEPTH_WORDS -> err=1.
  - size=3 -> err=1.
- Backpressure: hold resp_ready=0 for 5 cycles.
  - resp_valid and resp_rdata stay stable and req_ready stays 0.
  - When resp_ready rises, req_ready=1 in the next cycle.
- Reset mid-operation: assert reset one cycle after a load is accepted.
  - No resp_valid follows.
  - req_ready=1 in the cycle after reset deasserts.
  - A store accepted just before reset is still visible on a later load.
